mem_error_checker: RTL and testbench
====================================

Name: mem_error_checker

Overview:
- Passive checker at the far end of the memory error-injection path.
- Keeps a golden shadow of recently written words and compares each later read against it.
- Classifies mismatches as single-bit, double-bit or multi-bit, counts them, and logs each one into a pop-able FIFO.
- Sits on the same mem_access/mem_addr/mem_we/mem_wdata/mem_rdata bus the injector drives; used by self-checking SoC tests to confirm that injected faults are seen.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr.
- DATA_WIDTH, 64, width of the data words.
- SHADOW_DEPTH, 16, number of shadow entries; power of 2, at least 2.
- LOG_DEPTH, 8, number of error-log FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- check_enable  in  1  enables read comparison; writes always update the shadow
- clear  in  1  synchronous clear of shadow, pipeline, counters, FIFO and overflow flag
- mem_access  in  1  one bus access this cycle
- mem_addr  in  ADDR_WIDTH  access address
- mem_we  in  1  1 = write, 0 = read
- mem_wdata  in  DATA_WIDTH  write data (post-injection)
- mem_rdata  in  DATA_WIDTH  read data, valid in the same cycle as mem_access
- err_single  out  1  one-cycle pulse: single-bit mismatch
- err_double  out  1  one-cycle pulse: double-bit mismatch
- err_multi  out  1  one-cycle pulse: 3 or more bits mismatched
- log_valid  out  1  FIFO non-empty
- log_ready  in  1  pop handshake
- log_addr  out  ADDR_WIDTH  head entry address
- log_syndrome  out  DATA_WIDTH  head entry syndrome (golden XOR read data)
- log_class  out  2  head entry class: 01 single, 10 double, 11 multi
- log_overflow  out  1  sticky: an error was dropped because the FIFO was full
- check_count  out  32  reads compared against a shadow hit
- miss_count  out  32  reads with no valid shadow match
- single_count  out  32  single-bit errors detected
- double_count  out  32  double-bit errors detected
- multi_count  out  32  multi-bit errors detected

Behaviour:
- Reset: all outputs 0; all shadow valid bits 0; FIFO empty; pipeline empty.
- Shadow indexing:
  - IDX_W = log2(SHADOW_DEPTH); index = mem_addr[IDX_W-1:0].
  - Each entry holds valid, full address and data.
- Write (mem_access && mem_we): at the edge, the entry at index gets valid=1, addr=mem_addr, data=mem_wdata. This happens regardless of check_enable.
- Read (mem_access && !mem_we && check_enable): shadow lookup is combinational on the current contents.
  - A hit requires valid && stored addr == mem_addr.
  - Hit: the check_count increment and the stage-1 capture of {addr, golden XOR mem_rdata} both happen at edge N.
  - Miss: increment miss_count; nothing enters the pipeline.
- A write at edge N followed by a read of the same address in cycle N+1 compares against the new data.
- Stage 2 (edge N+1):
  - Popcount the syndrome: 0 means no error; 1 single; 2 double; 3 or more multi.
  - On an error, the matching err_* pulse is high for exactly the cycle after edge N+1.
  - The matching counter increments at edge N+1.
  - The FIFO push happens at edge N+1.
- Latency: read at edge N gives the error pulse and log entry visible after edge N+1. Throughput is one read per cycle.
- Counters: 32-bit, saturate at 0xFFFFFFFF, no wrap.
- FIFO: first-word-fallthrough.
  - log_* outputs show the head entry while log_valid=1.
  - Pop happens on log_valid && log_ready at the edge.
  - Push while full with no pop in the same cycle: the entry is dropped and log_overflow is set.
  - Push while full with a simultaneous pop: both happen; no overflow.
  - Pop while empty: ignored.
  - log_overflow holds until clear or reset.
- clear:
  - At the edge: all shadow valids are cleared; the pipeline is flushed, so no err_* pulse comes from in-flight reads; counters go to 0; FIFO empties; overflow goes to 0.
  - An access in the same cycle as clear is ignored.
- check_enable deasserted: reads are not compared or counted. Reads already in the pipeline still complete.
- Reset asserted mid-operation: asynchronous return to the reset state; in-flight results are lost.

Test Plan:
1. Single-bit error:
   - Stimulus: write 0x1000 = 0xDEADBEEF_CAFEF00D, then read 0x1000 returning 0xDEADBEEF_CAFEF00C.
   - Response: err_single pulses 2 cycles after the read; single_count=1, check_count=1; log_class=01, log_syndrome=0x1, log_addr=0x1000.
2. Double, multi and clean reads:
   - Stimulus: reads of the written word with syndromes 0x3 and 0xF0, then an exact read.
   - Response: one err_double and one err_multi pulse; the exact read gives no pulse; check_count=3, log holds 2 entries.
3. Shadow miss and alias:
   - Stimulus: write 0x0 with SHADOW_DEPTH=16, then read 0x10 (same index, different address).
   - Response: miss_count=1, check_count=0, no pulse. Then write 0x10 and read 0x0: miss_count=2.
4. FIFO overflow:
   - Stimulus: 9 consecutive single-bit errors with log_ready=0 (LOG_DEPTH=8).
   - Response: 8 entries logged; log_overflow=1; single_count=9.
   - Then with the FIFO full, hold log_ready=1 during one more error: entry count stays 8 and there is no new overflow.
5. Clear mid-pipeline:
   - Stimulus: error read at edge N, clear asserted in cycle N+1.
   - Response: no err_* pulse; all counters 0; log_valid=0; log_overflow=0; the next read of the old address is a miss.
6. Back-to-back and enable:
   - Stimulus: write at edge N and erroneous read of the same address at edge N+1, then check_enable=0 for a further erroneous read.
   - Response: exactly one error is detected against the new data; the disabled read leaves all counters unchanged.

Source files
------------

// File: rtl/mem_error_checker.sv
// Passive far-end checker: shadows recent writes, compares later reads, classifies
// mismatches by popcount, counts them and logs each into a first-word-fallthrough FIFO.
module mem_error_checker #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int SHADOW_DEPTH = 16,
    parameter int LOG_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  check_enable,
    input  logic                  clear,
    input  logic                  mem_access,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_single,
    output logic                  err_double,
    output logic                  err_multi,
    output logic                  log_valid,
    input  logic                  log_ready,
    output logic [ADDR_WIDTH-1:0] log_addr,
    output logic [DATA_WIDTH-1:0] log_syndrome,
    output logic [1:0]            log_class,
    output logic                  log_overflow,
    output logic [31:0]           check_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           single_count,
    output logic [31:0]           double_count,
    output logic [31:0]           multi_count
);

    localparam int              IDX_W    = $clog2(SHADOW_DEPTH);
    localparam int              LOG_W    = $clog2(LOG_DEPTH);
    localparam logic [LOG_W:0]  LOG_FULL = (LOG_W+1)'(LOG_DEPTH);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating popcount: 0 clean, 1 single, 2 double, 3 multi (matches log_class).
    function automatic logic [1:0] classify(input logic [DATA_WIDTH-1:0] syn);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (syn[i] && (c != 2'd3)) c = c + 2'd1;
        end
        return c;
    endfunction

    logic [SHADOW_DEPTH-1:0] sh_valid_q, sh_valid_d;
    logic [ADDR_WIDTH-1:0]   sh_addr_q [SHADOW_DEPTH];
    logic [DATA_WIDTH-1:0]   sh_data_q [SHADOW_DEPTH];

    logic [IDX_W-1:0] idx;
    logic             wr_req, rd_req, hit;

    logic                  vld_p1_q, vld_p1_d;
    logic [ADDR_WIDTH-1:0] addr_p1_q;
    logic [DATA_WIDTH-1:0] syn_p1_q;

    logic [1:0] cls_p2;
    logic       err_p2;

    logic err_single_q, err_single_d;
    logic err_double_q, err_double_d;
    logic err_multi_q,  err_multi_d;

    logic [31:0] check_q, check_d, miss_q, miss_d;
    logic [31:0] single_q, single_d, double_q, double_d, multi_q, multi_d;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [LOG_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_syn_q  [LOG_DEPTH];
    logic [1:0]            fifo_cls_q  [LOG_DEPTH];
    logic [LOG_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop, full, do_write;

    // Stage 0: shadow lookup on current contents; an access during clear is ignored.
    assign idx    = mem_addr[IDX_W-1:0];
    assign wr_req = mem_access && mem_we && !clear;
    assign rd_req = mem_access && !mem_we && check_enable && !clear;
    assign hit    = sh_valid_q[idx] && (sh_addr_q[idx] == mem_addr);

    always_comb begin
        sh_valid_d = sh_valid_q;
        if (clear) begin
            sh_valid_d = '0;
        end else if (wr_req) begin
            sh_valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req) begin
            sh_addr_q[idx] <= mem_addr;
            sh_data_q[idx] <= mem_wdata;
        end
    end

    // Stage 1: capture address and syndrome of a shadow hit.
    assign vld_p1_d = rd_req && hit;

    always_ff @(posedge clk) begin
        if (vld_p1_d) begin
            addr_p1_q <= mem_addr;
            syn_p1_q  <= sh_data_q[idx] ^ mem_rdata;
        end
    end

    // Stage 2: classify; clear flushes the in-flight result.
    assign cls_p2 = classify(syn_p1_q);
    assign err_p2 = vld_p1_q && (cls_p2 != 2'd0) && !clear;

    assign err_single_d = err_p2 && (cls_p2 == 2'd1);
    assign err_double_d = err_p2 && (cls_p2 == 2'd2);
    assign err_multi_d  = err_p2 && (cls_p2 == 2'd3);

    always_comb begin
        check_d  = check_q;
        miss_d   = miss_q;
        single_d = single_q;
        double_d = double_q;
        multi_d  = multi_q;
        if (clear) begin
            check_d  = '0;
            miss_d   = '0;
            single_d = '0;
            double_d = '0;
            multi_d  = '0;
        end else begin
            if (rd_req && hit)  check_d  = sat_inc(check_q);
            if (rd_req && !hit) miss_d   = sat_inc(miss_q);
            if (err_single_d)   single_d = sat_inc(single_q);
            if (err_double_d)   double_d = sat_inc(double_q);
            if (err_multi_d)    multi_d  = sat_inc(multi_q);
        end
    end

    // Error log: a push into a full FIFO only lands if a pop frees the head this edge.
    assign full     = ((wr_ptr_q - rd_ptr_q) == LOG_FULL);
    assign push     = err_p2;
    assign pop      = log_valid && log_ready;
    assign do_write = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_write)              wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)                   rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && full && !pop)  ovf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !clear) begin
            fifo_addr_q[wr_ptr_q[LOG_W-1:0]] <= addr_p1_q;
            fifo_syn_q[wr_ptr_q[LOG_W-1:0]]  <= syn_p1_q;
            fifo_cls_q[wr_ptr_q[LOG_W-1:0]]  <= cls_p2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid_q   <= '0;
            vld_p1_q     <= 1'b0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            err_multi_q  <= 1'b0;
            check_q      <= '0;
            miss_q       <= '0;
            single_q     <= '0;
            double_q     <= '0;
            multi_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sh_valid_q   <= sh_valid_d;
            vld_p1_q     <= vld_p1_d;
            err_single_q <= err_single_d;
            err_double_q <= err_double_d;
            err_multi_q  <= err_multi_d;
            check_q      <= check_d;
            miss_q       <= miss_d;
            single_q     <= single_d;
            double_q     <= double_d;
            multi_q      <= multi_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
        end
    end

    // Head fields are forced to zero while empty so stale storage never shows.
    assign log_valid    = (wr_ptr_q != rd_ptr_q);
    assign log_addr     = log_valid ? fifo_addr_q[rd_ptr_q[LOG_W-1:0]] : '0;
    assign log_syndrome = log_valid ? fifo_syn_q[rd_ptr_q[LOG_W-1:0]]  : '0;
    assign log_class    = log_valid ? fifo_cls_q[rd_ptr_q[LOG_W-1:0]]  : 2'd0;
    assign log_overflow = ovf_q;

    assign err_single   = err_single_q;
    assign err_double   = err_double_q;
    assign err_multi    = err_multi_q;
    assign check_count  = check_q;
    assign miss_count   = miss_q;
    assign single_count = single_q;
    assign double_count = double_q;
    assign multi_count  = multi_q;

endmodule

// File: tb/tb_mem_error_checker.sv
// Directed self-checking bench for mem_error_checker.
module tb_mem_error_checker;

    logic        clk = 1'b0;
    logic        rst_n, check_enable, clear, mem_access, mem_we, log_ready;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        err_single, err_double, err_multi, log_valid, log_overflow;
    logic [31:0] log_addr;
    logic [63:0] log_syndrome;
    logic [1:0]  log_class;
    logic [31:0] check_count, miss_count, single_count, double_count, multi_count;

    int checks   = 0;
    int failures = 0;
    int n;

    localparam logic [63:0] W  = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D  = 64'h01234567_89ABCDEF;
    localparam logic [63:0] D0 = 64'h00000000_00000000;
    localparam logic [63:0] D1 = 64'hA5A5A5A5_5A5A5A5A;

    mem_error_checker dut (
        .clk(clk), .rst_n(rst_n), .check_enable(check_enable), .clear(clear),
        .mem_access(mem_access), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_single(err_single), .err_double(err_double), .err_multi(err_multi),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
        .log_syndrome(log_syndrome), .log_class(log_class), .log_overflow(log_overflow),
        .check_count(check_count), .miss_count(miss_count), .single_count(single_count),
        .double_count(double_count), .multi_count(multi_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [31:0] a, input logic [63:0] d);
        mem_access = 1'b1;
        mem_we     = we;
        mem_addr   = a;
        if (we) mem_wdata = d;
        else    mem_rdata = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        mem_access = 1'b0;
        mem_we     = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; check_enable = 1'b1; clear = 1'b0; mem_access = 1'b0;
        mem_we = 1'b0; log_ready = 1'b0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_log_valid", log_valid, 0);
        chk("rst_overflow", log_overflow, 0);
        chk("rst_check_count", check_count, 0);
        chk("rst_err_single", err_single, 0);
        chk("rst_log_addr", log_addr, 0);
        rst_n = 1'b1;
        idle();

        // Single-bit error
        acc(1'b1, 32'h1000, W);
        acc(1'b0, 32'h1000, W ^ 64'h1);
        chk("t1_check_count", check_count, 1);
        chk("t1_no_early_pulse", err_single, 0);
        idle();
        chk("t1_err_single", err_single, 1);
        chk("t1_err_double", err_double, 0);
        chk("t1_single_count", single_count, 1);
        chk("t1_log_valid", log_valid, 1);
        chk("t1_log_class", log_class, 2'b01);
        chk("t1_log_syndrome", log_syndrome, 64'h1);
        chk("t1_log_addr", log_addr, 32'h1000);
        idle();
        chk("t1_pulse_ends", err_single, 0);
        log_ready = 1'b1;
        idle();
        log_ready = 1'b0;
        chk("t1_popped", log_valid, 0);

        // Double, multi and clean reads back to back
        acc(1'b0, 32'h1000, W ^ 64'h3);
        acc(1'b0, 32'h1000, W ^ 64'hF0);
        chk("t2_err_double", err_double, 1);
        acc(1'b0, 32'h1000, W);
        chk("t2_err_multi", err_multi, 1);
        chk("t2_no_double", err_double, 0);
        idle();
        chk("t2_clean_no_multi", err_multi, 0);
        chk("t2_clean_no_single", err_single, 0);
        chk("t2_check_count", check_count, 4);
        chk("t2_double_count", double_count, 1);
        chk("t2_multi_count", multi_count, 1);
        chk("t2_head_class", log_class, 2'b10);
        chk("t2_head_syn", log_syndrome, 64'h3);
        log_ready = 1'b1;
        idle();
        log_ready = 1'b0;
        chk("t2_second_class", log_class, 2'b11);
        chk("t2_second_syn", log_syndrome, 64'hF0);
        log_ready = 1'b1;
        idle();
        log_ready = 1'b0;
        chk("t2_log_empty", log_valid, 0);

        // Shadow miss and alias
        acc(1'b1, 32'h0, 64'h1234);
        acc(1'b0, 32'h10, 64'h1234);
        chk("t3_miss1", miss_count, 1);
        chk("t3_check_same", check_count, 4);
        idle();
        chk("t3_no_pulse", err_single | err_double | err_multi, 0);
        acc(1'b1, 32'h10, 64'h5678);
        acc(1'b0, 32'h0, 64'h5678);
        chk("t3_miss2", miss_count, 2);

        // FIFO overflow
        acc(1'b1, 32'h5, D);
        for (int i = 0; i < 9; i++) acc(1'b0, 32'h5, D ^ 64'h1);
        chk("t4_no_ovf_at_8", log_overflow, 0);
        idle();
        chk("t4_overflow", log_overflow, 1);
        chk("t4_single_count", single_count, 10);
        acc(1'b0, 32'h5, D ^ 64'h1);
        log_ready = 1'b1;
        idle();
        log_ready = 1'b1;
        n = 0;
        while (log_valid && n < 20) begin
            n++;
            idle();
        end
        log_ready = 1'b0;
        chk("t4_entries", n, 8);
        chk("t4_single_after_pop", single_count, 11);
        chk("t4_check_count", check_count, 14);

        // Clear mid-pipeline
        acc(1'b0, 32'h5, D ^ 64'h1);
        mem_access = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t5_no_pulse", err_single, 0);
        chk("t5_check_cleared", check_count, 0);
        chk("t5_miss_cleared", miss_count, 0);
        chk("t5_single_cleared", single_count, 0);
        chk("t5_log_valid", log_valid, 0);
        chk("t5_overflow_cleared", log_overflow, 0);
        acc(1'b0, 32'h5, D ^ 64'h1);
        chk("t5_old_addr_miss", miss_count, 1);
        idle();
        chk("t5_miss_no_pulse", err_single, 0);

        // Back-to-back write/read and check_enable
        acc(1'b1, 32'h7, D0);
        acc(1'b1, 32'h7, D1);
        acc(1'b0, 32'h7, D1 ^ 64'h8000_0000_0000_0000);
        idle();
        chk("t6_err_single", err_single, 1);
        chk("t6_err_multi", err_multi, 0);
        chk("t6_syn", log_syndrome, 64'h8000_0000_0000_0000);
        chk("t6_check_count", check_count, 1);
        check_enable = 1'b0;
        acc(1'b0, 32'h7, D1 ^ 64'hFF);
        idle();
        chk("t6_dis_no_pulse", err_multi, 0);
        idle();
        chk("t6_dis_check", check_count, 1);
        chk("t6_dis_miss", miss_count, 1);
        chk("t6_dis_single", single_count, 1);
        chk("t6_dis_multi", multi_count, 0);
        check_enable = 1'b1;

        // Asynchronous reset mid-operation
        acc(1'b0, 32'h7, D1 ^ 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_check", check_count, 0);
        chk("rst_async_log", log_valid, 0);
        chk("rst_async_miss", miss_count, 0);
        mem_access = 1'b0;
        @(posedge clk); #1;
        chk("rst_async_no_pulse", err_single, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
